// File: rtl/gray_pkg.sv
// Gray-code helpers and side selectors shared by the FIFO pointer blocks.
// Functions work on zero-extended 32-bit values, so they fit any width.
package gray_pkg;

  localparam int SIDE_WR = 0;
  localparam int SIDE_RD = 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_p.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB).
// Ports: g = Gray input (W bits), b = binary output (W bits).
module gray2bin_p #(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an async FIFO: local binary/Gray pointer, full or empty
// flag, and fill level.
// Ports: clk, rst (async, high); inc = advance request; remote_gray =
// synced far-side Gray pointer; ack = inc accepted; ptr_bin/ptr_gray =
// local pointer; addr = RAM address; flag = full (write) / empty (read);
// level = fill count.
module gray_ptr_ctrl
  import gray_pkg::*;
#(
  parameter int AW        = 8,
  parameter int SIDE      = 0,
  parameter int CONV_PIPE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [AW:0]   remote_gray,
  output logic          ack,
  output logic [AW:0]   ptr_bin,
  output logic [AW:0]   ptr_gray,
  output logic [AW-1:0] addr,
  output logic          flag,
  output logic [AW:0]   level
);

  localparam int N = AW + 1;

  logic [N-1:0] nb;
  logic [N-1:0] ng;
  logic [N-1:0] rg_cmp;
  logic [N-1:0] rbin_c;
  logic [N-1:0] rbin;
  logic [N-1:0] level_nx;
  logic         flag_nx;

  assign ack  = inc & ~flag;
  assign addr = ptr_bin[AW-1:0];
  assign nb   = ptr_bin + N'(ack);
  assign ng   = N'(bin2gray(32'(nb)));

  gray2bin_p #(
    .W (N)
  ) u_g2b (
    .g (remote_gray),
    .b (rbin_c)
  );

  if (CONV_PIPE != 0) begin : g_pipe
    logic [N-1:0] rbin_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rbin_q <= '0;
      end else begin
        rbin_q <= rbin_c;
      end
    end
    assign rbin = rbin_q;
  end else begin : g_comb
    assign rbin = rbin_c;
  end

  // Full: remote is one lap behind, which in Gray means the two
  // MSBs are inverted and the rest match.
  if (SIDE == SIDE_WR) begin : g_wr
    assign rg_cmp   = {~remote_gray[AW:AW-1], remote_gray[AW-2:0]};
    assign level_nx = nb - rbin;
  end else begin : g_rd
    assign rg_cmp   = remote_gray;
    assign level_nx = rbin - nb;
  end

  assign flag_nx = (ng == rg_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_bin  <= '0;
      ptr_gray <= '0;
      flag     <= (SIDE == SIDE_RD);
      level    <= '0;
    end else begin
      ptr_bin  <= nb;
      ptr_gray <= ng;
      flag     <= flag_nx;
      level    <= level_nx;
    end
  end

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Scoreboard bench for gray_ptr_ctrl: write/read sides with a conversion
// pipe and a write side without it, driven by directed vectors.
module tb_gray_ptr_ctrl;

  localparam int AW = 3;
  localparam int N  = AW + 1;

  typedef enum int {
    F_ACK, F_PBIN, F_PGRAY, F_FLAG, F_LEVEL, F_ADDR, F_GSTEP
  } fld_t;

  typedef struct {
    string        nm;
    int           d;
    fld_t         f;
    logic [N-1:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rst;
  logic [2:0]    inc;
  logic [2:0]    ack;
  logic [2:0]    flg;
  logic [N-1:0]  rg [3];
  logic [N-1:0]  pb [3];
  logic [N-1:0]  pg [3];
  logic [N-1:0]  lv [3];
  logic [AW-1:0] ad [3];

  gray_ptr_ctrl #(.AW(AW), .SIDE(0), .CONV_PIPE(1)) u_w1 (
    .clk(clk), .rst(rst[0]), .inc(inc[0]), .remote_gray(rg[0]),
    .ack(ack[0]), .ptr_bin(pb[0]), .ptr_gray(pg[0]), .addr(ad[0]),
    .flag(flg[0]), .level(lv[0])
  );

  gray_ptr_ctrl #(.AW(AW), .SIDE(1), .CONV_PIPE(1)) u_r1 (
    .clk(clk), .rst(rst[1]), .inc(inc[1]), .remote_gray(rg[1]),
    .ack(ack[1]), .ptr_bin(pb[1]), .ptr_gray(pg[1]), .addr(ad[1]),
    .flag(flg[1]), .level(lv[1])
  );

  gray_ptr_ctrl #(.AW(AW), .SIDE(0), .CONV_PIPE(0)) u_w0 (
    .clk(clk), .rst(rst[2]), .inc(inc[2]), .remote_gray(rg[2]),
    .ack(ack[2]), .ptr_bin(pb[2]), .ptr_gray(pg[2]), .addr(ad[2]),
    .flag(flg[2]), .level(lv[2])
  );

  exp_t         q [$];
  event         smp;
  int           nchk  = 0;
  int           nfail = 0;
  logic [N-1:0] prev [3] = '{default: '0};
  exp_t         e;
  logic [N-1:0] a;

  function automatic logic [N-1:0] g(input logic [N-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [N-1:0] act_of(input int d, input fld_t f);
    case (f)
      F_ACK:   return N'(ack[d]);
      F_PBIN:  return pb[d];
      F_PGRAY: return pg[d];
      F_FLAG:  return N'(flg[d]);
      F_LEVEL: return lv[d];
      F_ADDR:  return N'(ad[d]);
      default: return 'x;
    endcase
  endfunction

  task automatic px(input string nm, input int d, input fld_t f,
                    input logic [N-1:0] v);
    exp_t x;
    x.nm = nm;
    x.d  = d;
    x.f  = f;
    x.v  = v;
    q.push_back(x);
  endtask

  task automatic chk();
    ->smp;
    #1;
  endtask

  // Monitor: pops every queued expectation when a sample point is raised.
  always begin
    @(smp);
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.f == F_GSTEP) begin
        a = N'($countones(pg[e.d] ^ prev[e.d]));
        prev[e.d] = pg[e.d];
      end else begin
        a = act_of(e.d, e.f);
      end
      nchk++;
      if (a !== e.v) begin
        nfail++;
        $display("FAIL %s (dut %0d) at %0t: got %h want %h",
                 e.nm, e.d, $time, a, e.v);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = '0;
    inc = '0;
    for (int i = 0; i < 3; i++) rg[i] = '0;

    // Reset without any clock edge
    #2;
    rst = 3'b111;
    #1;
    for (int d = 0; d < 3; d++) begin
      px("rst_pgray", d, F_PGRAY, 4'b0000);
      px("rst_pbin",  d, F_PBIN,  4'b0000);
      px("rst_level", d, F_LEVEL, 4'b0000);
      px("rst_flag",  d, F_FLAG,  (d == 1) ? 4'd1 : 4'd0);
    end
    chk();
    rst = '0;

    // Drain, read side
    @(negedge clk);
    inc[1] = 1'b1;
    #1;
    px("empty_ack", 1, F_ACK, 4'd0);
    chk();
    inc[1] = 1'b0;
    rg[1]  = 4'b0111;
    @(posedge clk); #1;
    px("drain_stale_level", 1, F_LEVEL, 4'd0);
    chk();
    @(posedge clk); #1;
    px("drain_flag0",  1, F_FLAG,  4'd0);
    px("drain_level5", 1, F_LEVEL, 4'd5);
    chk();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      inc[1] = 1'b1;
      #1;
      px("drain_ack", 1, F_ACK, N'(k <= 5));
      chk();
      @(posedge clk); #1;
      px("drain_pbin",  1, F_PBIN,  N'(k <= 5 ? k : 5));
      px("drain_level", 1, F_LEVEL, N'(k <= 5 ? 5 - k : 0));
      px("drain_flag",  1, F_FLAG,  N'(k >= 5));
      chk();
    end
    @(negedge clk);
    inc[1] = 1'b0;

    // Fill, write side, remote at zero
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      inc[0] = 1'b1;
      #1;
      px("fill_ack", 0, F_ACK, N'(k <= 8));
      chk();
      @(posedge clk); #1;
      px("fill_pbin",  0, F_PBIN,  N'(k <= 8 ? k : 8));
      px("fill_level", 0, F_LEVEL, N'(k <= 8 ? k : 8));
      px("fill_flag",  0, F_FLAG,  N'(k >= 8));
      if (k >= 8) begin
        px("fill_pgray", 0, F_PGRAY, 4'b1100);
        px("fill_addr",  0, F_ADDR,  4'd0);
      end
      chk();
    end
    @(negedge clk);
    inc[0] = 1'b0;

    // Wrap with remote trailing by two cycles
    @(negedge clk);
    rst[0] = 1'b1;
    rg[0]  = '0;
    #1;
    rst[0] = 1'b0;
    px("wrap_rst_pgray", 0, F_PGRAY, 4'b0000);
    px("wrap_base", 0, F_GSTEP, 4'd0);
    chk();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rg[0]  = g(N'(k >= 2 ? k - 2 : 0));
      inc[0] = 1'b1;
      #1;
      px("wrap_ack", 0, F_ACK, 4'd1);
      chk();
      @(posedge clk); #1;
      px("wrap_pbin",  0, F_PBIN,  N'(k));
      px("wrap_pgray", 0, F_PGRAY, g(N'(k)));
      px("wrap_flag",  0, F_FLAG,  4'd0);
      px("wrap_level", 0, F_LEVEL, N'(k < 3 ? k : 3));
      px("wrap_gstep", 0, F_GSTEP, 4'd1);
      chk();
    end
    @(negedge clk);
    inc[0] = 1'b0;

    // Simultaneous local inc and remote advance at level 7
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    rst[0] = 1'b0;
    rg[0]  = '0;
    inc[0] = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    px("sim_pbin7",  0, F_PBIN,  4'd7);
    px("sim_level7", 0, F_LEVEL, 4'd7);
    px("sim_flag0",  0, F_FLAG,  4'd0);
    chk();
    @(negedge clk);
    rg[0] = 4'b0001;
    #1;
    px("sim_ack", 0, F_ACK, 4'd1);
    chk();
    @(posedge clk); #1;
    px("sim_pbin8",   0, F_PBIN,  4'd8);
    px("sim_flag",    0, F_FLAG,  4'd0);
    px("sim_stale_lv", 0, F_LEVEL, 4'd8);
    chk();
    @(negedge clk);
    inc[0] = 1'b0;
    @(posedge clk); #1;
    px("sim_settle_flag",  0, F_FLAG,  4'd0);
    px("sim_settle_level", 0, F_LEVEL, 4'd7);
    chk();

    // Mid-operation reset, no conversion pipe
    @(negedge clk);
    inc[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    px("mid_pbin3",  2, F_PBIN,  4'd3);
    px("mid_level3", 2, F_LEVEL, 4'd3);
    chk();
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    px("mid_rst_pbin",  2, F_PBIN,  4'd0);
    px("mid_rst_pgray", 2, F_PGRAY, 4'd0);
    px("mid_rst_level", 2, F_LEVEL, 4'd0);
    px("mid_rst_flag",  2, F_FLAG,  4'd0);
    px("mid_rst_addr",  2, F_ADDR,  4'd0);
    chk();
    if (ad[2] !== pb[2][AW-1:0]) begin
      nfail++;
      $display("FAIL mid_addr_match at %0t: addr %h pbin %h",
               $time, ad[2], pb[2]);
    end
    @(negedge clk);
    rst[2] = 1'b0;
    @(posedge clk); #1;
    px("mid_first_pbin",  2, F_PBIN,  4'd1);
    px("mid_first_level", 2, F_LEVEL, 4'd1);
    chk();
    @(negedge clk);
    inc[2] = 1'b0;
    rg[2]  = 4'b0011;
    @(posedge clk); #1;
    px("mid_hold_pbin", 2, F_PBIN,  4'd1);
    px("mid_rlevel",    2, F_LEVEL, 4'hF);
    px("mid_flag",      2, F_FLAG,  4'd0);
    chk();

    chk();
    if (nchk < 12) begin
      nfail++;
      $display("FAIL too few checks: %0d", nchk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
